vm2002_change_dispenser: RTL and testbench

Change-return engine for the vm2002 vending machine, on the output side of the machine's balance path. On a refund request it latches the 16-bit balance in cents and pays it out as a sequence of coins: quarter, dime, nickel. The payout is greedy, limited by its own per-denomination coin stock. It drives a coin hopper over a valid/ack handshake, is restocked by the supplier over a fill port, and reports any amount it could not pay.

---
 rtl/vm2002_change_dispenser.sv | 189 ++++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm2002_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : vm2002_change_dispenser
// Description : Change-return engine for the vm2002 vending machine. Latches
//               the balance on a refund request and pays it out greedily as
//               quarters, dimes and nickels, limited by per-denomination coin
//               stock, over a valid/ack hopper handshake. Restocked through a
//               fill port; reports any unpaid remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module vm2002_change_dispenser #(
    parameter int MAX_STOCK = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refund_req,
    input  logic [15:0] balance,
    output logic [1:0]  coin_out,
    output logic        coin_valid,
    input  logic        coin_ack,
    input  logic        fill_valid,
    input  logic [1:0]  fill_coin,
    input  logic [7:0]  fill_count,
    output logic        busy,
    output logic        done,
    output logic        short,
    output logic [15:0] remainder,
    output logic [7:0]  stock_q,
    output logic [7:0]  stock_d,
    output logic [7:0]  stock_n
);

    // ------------------------------------------------------------------------
    // Coin encodings and values
    // ------------------------------------------------------------------------
    localparam logic [1:0]  C_COIN_NONE = 2'b00;
    localparam logic [1:0]  C_COIN_N    = 2'b01;
    localparam logic [1:0]  C_COIN_D    = 2'b10;
    localparam logic [1:0]  C_COIN_Q    = 2'b11;

    localparam logic [15:0] C_VAL_N     = 16'd5;
    localparam logic [15:0] C_VAL_D     = 16'd10;
    localparam logic [15:0] C_VAL_Q     = 16'd25;

    // Saturation ceiling; the stock counters are 8 bits wide.
    localparam logic [7:0]  C_MAX_STOCK = 8'(MAX_STOCK);

    // ------------------------------------------------------------------------
    // Payout state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;

    logic [1:0] w_sel_coin;
    logic       w_fill_en;
    logic       w_xfer;

    // Value in cents of an encoded coin.
    function automatic logic [15:0] coin_value(input logic [1:0] coin);
        logic [15:0] val;
        case (coin)
            C_COIN_Q: val = C_VAL_Q;
            C_COIN_D: val = C_VAL_D;
            C_COIN_N: val = C_VAL_N;
            default:  val = 16'd0;
        endcase
        return val;
    endfunction

    // Add a fill count to a stock, widened to 9 bits so the carry is seen,
    // then clamp at the stock ceiling.
    function automatic logic [7:0] sat_add(input logic [7:0] stock,
                                           input logic [7:0] count);
        logic [8:0] sum;
        sum = {1'b0, stock} + {1'b0, count};
        if (sum > {1'b0, C_MAX_STOCK}) begin
            return C_MAX_STOCK;
        end
        return sum[7:0];
    endfunction

    // Fill is only honoured while no payout is running, so it can never
    // collide with a stock decrement from a transfer.
    assign w_fill_en = fill_valid && !busy;

    // A coin leaves the machine when the hopper acks a presented coin.
    assign w_xfer    = coin_valid && coin_ack;

    // Greedy choice: largest coin that fits in the remainder and is in stock.
    always_comb begin
        w_sel_coin = C_COIN_NONE;
        if ((remainder >= C_VAL_Q) && (stock_q != 8'd0)) begin
            w_sel_coin = C_COIN_Q;
        end else if ((remainder >= C_VAL_D) && (stock_d != 8'd0)) begin
            w_sel_coin = C_COIN_D;
        end else if ((remainder >= C_VAL_N) && (stock_n != 8'd0)) begin
            w_sel_coin = C_COIN_N;
        end
    end

    // Payout sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            coin_out   <= C_COIN_NONE;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            remainder  <= 16'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (refund_req) begin
                        remainder <= balance;
                        short     <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (w_sel_coin != C_COIN_NONE) begin
                        coin_out   <= w_sel_coin;
                        coin_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        // Nothing more can be paid: busy falls together with
                        // the done pulse, and short is already valid with it.
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        short   <= (remainder != 16'd0);
                        r_state <= S_DONE;
                    end
                end

                S_ISSUE: begin
                    // coin_out/coin_valid hold for as long as the hopper stalls.
                    if (coin_ack) begin
                        remainder  <= remainder - coin_value(coin_out);
                        coin_out   <= C_COIN_NONE;
                        coin_valid <= 1'b0;
                        r_state    <= S_SELECT;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Coin stock counters: saturating restock when idle, decrement per coin paid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stock_q <= 8'd0;
            stock_d <= 8'd0;
            stock_n <= 8'd0;
        end else if (w_fill_en) begin
            case (fill_coin)
                C_COIN_Q: stock_q <= sat_add(stock_q, fill_count);
                C_COIN_D: stock_d <= sat_add(stock_d, fill_count);
                C_COIN_N: stock_n <= sat_add(stock_n, fill_count);
                default:  ;
            endcase
        end else if (w_xfer) begin
            case (coin_out)
                C_COIN_Q: stock_q <= stock_q - 8'd1;
                C_COIN_D: stock_d <= stock_d - 8'd1;
                C_COIN_N: stock_n <= stock_n - 8'd1;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vm2002_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_vm2002_change_dispenser
// Description : Self-checking bench for vm2002_change_dispenser: table of
//               payout scenarios, hand-written timing sequences, and random
//               fills/payouts checked against a greedy reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vm2002_change_dispenser;

    logic        clk = 1'b0;
    logic        rst;
    logic        refund_req;
    logic [15:0] balance;
    logic [1:0]  coin_out;
    logic        coin_valid;
    logic        coin_ack;
    logic        fill_valid;
    logic [1:0]  fill_coin;
    logic [7:0]  fill_count;
    logic        busy;
    logic        done;
    logic        short;
    logic [15:0] remainder;
    logic [7:0]  stock_q;
    logic [7:0]  stock_d;
    logic [7:0]  stock_n;

    always #5 clk = ~clk;

    vm2002_change_dispenser #(.MAX_STOCK(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .refund_req (refund_req),
        .balance    (balance),
        .coin_out   (coin_out),
        .coin_valid (coin_valid),
        .coin_ack   (coin_ack),
        .fill_valid (fill_valid),
        .fill_coin  (fill_coin),
        .fill_count (fill_count),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remainder  (remainder),
        .stock_q    (stock_q),
        .stock_d    (stock_d),
        .stock_n    (stock_n)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: coin stocks and the expected coin sequence.
    int         mq, md, mn;
    logic [1:0] exp_q[$];
    logic [1:0] got_coins[$];
    logic [15:0] done_rem;
    logic        done_short;
    bit          done_seen;

    typedef struct {
        bit rst_first;
        int fq, fd, fn;
        int bal;
        int ncoins;
        int first;
        int rem;
        int sh;
        int sq, sd, sn;
    } vec_t;

    typedef struct {
        int busy_e;
        int valid_e;
        int coin_e;
        int done_e;
    } step_t;

    vec_t  vecs[8];
    step_t steps[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; refund_req = 1'b0; fill_valid = 1'b0; coin_ack = 1'b0;
        balance = 16'd0; fill_coin = 2'd0; fill_count = 8'd0;
        tick();
        rst = 1'b1;
        mq = 0; md = 0; mn = 0;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Idle-time restock of one denomination (model updated alongside).
    task automatic fill_one(input logic [1:0] coin, input logic [7:0] cnt);
        fill_valid = 1'b1; fill_coin = coin; fill_count = cnt;
        tick();
        fill_valid = 1'b0;
        case (coin)
            2'b11: mq = sat(mq + int'(cnt));
            2'b10: md = sat(md + int'(cnt));
            2'b01: mn = sat(mn + int'(cnt));
            default: ;
        endcase
    endtask

    // Greedy payout computed directly from the coin rules.
    function automatic int model_payout(input int bal);
        int rem;
        bit more;
        rem = bal;
        more = 1'b1;
        exp_q.delete();
        while (more) begin
            if (rem >= 25 && mq > 0) begin
                exp_q.push_back(2'b11); rem -= 25; mq--;
            end else if (rem >= 10 && md > 0) begin
                exp_q.push_back(2'b10); rem -= 10; md--;
            end else if (rem >= 5 && mn > 0) begin
                exp_q.push_back(2'b01); rem -= 5; mn--;
            end else begin
                more = 1'b0;
            end
        end
        return rem;
    endfunction

    // Request a payout and act as the hopper until done; acks randomly
    // stall up to stall_max cycles, and random acks are also driven while
    // no coin is presented.
    task automatic run_payout(input logic [15:0] bal, input int stall_max);
        int cyc;
        cyc = 0;
        got_coins.delete();
        done_seen = 1'b0;
        balance = bal; refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        while (!done_seen && cyc < 20000) begin
            if (done) begin
                done_seen = 1'b1; done_rem = remainder; done_short = short;
            end else begin
                if (coin_valid)
                    coin_ack = (stall_max == 0) || ($urandom_range(0, stall_max) == 0);
                else
                    coin_ack = ($urandom_range(0, 1) == 1);
                if (coin_valid && coin_ack) got_coins.push_back(coin_out);
                tick();
                cyc++;
            end
        end
        coin_ack = 1'b0;
        chk("payout_done_seen", 32'(done_seen), 1);
        tick();
    endtask

    // Wait for done with a cycle bound, counting transfers on the way.
    task automatic wait_done(input int bound, output int ncoins, output bit seen);
        ncoins = 0;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (coin_valid && coin_ack) ncoins++;
                tick();
            end
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        int  exp_rem;
        int  mism;
        logic [15:0] bal;

        vecs[0] = '{1'b1, 10, 10, 10,    40,  3, 3,     0, 0,  9,  9,  9};
        vecs[1] = '{1'b1,  0,  5,  1,    30,  3, 2,     0, 0,  0,  2,  1};
        vecs[2] = '{1'b1,  0,  0,  1,    25,  1, 1,    20, 1,  0,  0,  0};
        vecs[3] = '{1'b1, 20, 20, 20,     7,  1, 1,     2, 1, 20, 20, 19};
        vecs[4] = '{1'b0,  0,  0,  0,     0,  0, 0,     0, 0, 20, 20, 19};
        vecs[5] = '{1'b0,  0,  0,  0,   100,  4, 3,     0, 0, 16, 20, 19};
        vecs[6] = '{1'b0,  0,  0,  0,     3,  0, 0,     3, 1, 16, 20, 19};
        vecs[7] = '{1'b0,  0,  0,  0, 65535, 55, 3, 64840, 1,  0,  0,  0};

        // busy, coin_valid, coin_out, done per cycle after the request edge
        steps[0] = '{1, 0, 0, 0};
        steps[1] = '{1, 1, 3, 0};
        steps[2] = '{1, 0, 0, 0};
        steps[3] = '{1, 1, 2, 0};
        steps[4] = '{1, 0, 0, 0};
        steps[5] = '{1, 1, 1, 0};
        steps[6] = '{1, 0, 0, 0};
        steps[7] = '{0, 0, 0, 1};
        steps[8] = '{0, 0, 0, 0};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_coin_valid", 32'(coin_valid), 0);
        chk("rst_coin_out",   32'(coin_out),   0);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_done",       32'(done),       0);
        chk("rst_short",      32'(short),      0);
        chk("rst_remainder",  32'(remainder),  0);
        chk("rst_stocks",     {8'd0, stock_q, stock_d, stock_n}, 0);

        // ---------------- basic payout cycle timing ----------------
        fill_one(2'b11, 8'd10); fill_one(2'b10, 8'd10); fill_one(2'b01, 8'd10);
        coin_ack = 1'b1; balance = 16'd40; refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("basic_c%0d_busy", i),  32'(busy),       steps[i].busy_e);
            chk($sformatf("basic_c%0d_valid", i), 32'(coin_valid), steps[i].valid_e);
            chk($sformatf("basic_c%0d_coin", i),  32'(coin_out),   steps[i].coin_e);
            chk($sformatf("basic_c%0d_done", i),  32'(done),       steps[i].done_e);
            if (i == 7) begin
                chk("basic_short", 32'(short),     0);
                chk("basic_rem",   32'(remainder), 0);
            end
            if (i < 8) tick();
        end
        coin_ack = 1'b0;
        chk("basic_stocks", {8'd0, stock_q, stock_d, stock_n}, {8'd0, 8'd9, 8'd9, 8'd9});

        // ---------------- table of payout scenarios ----------------
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_first) do_reset();
            if (vecs[v].fq > 0) fill_one(2'b11, 8'(vecs[v].fq));
            if (vecs[v].fd > 0) fill_one(2'b10, 8'(vecs[v].fd));
            if (vecs[v].fn > 0) fill_one(2'b01, 8'(vecs[v].fn));
            run_payout(16'(vecs[v].bal), 0);
            chk($sformatf("vec%0d_ncoins", v), 32'(got_coins.size()), vecs[v].ncoins);
            if (got_coins.size() > 0)
                chk($sformatf("vec%0d_first", v), 32'(got_coins[0]), vecs[v].first);
            chk($sformatf("vec%0d_rem", v),   32'(done_rem),   vecs[v].rem);
            chk($sformatf("vec%0d_short", v), 32'(done_short), vecs[v].sh);
            chk($sformatf("vec%0d_sq", v), 32'(stock_q), vecs[v].sq);
            chk($sformatf("vec%0d_sd", v), 32'(stock_d), vecs[v].sd);
            chk($sformatf("vec%0d_sn", v), 32'(stock_n), vecs[v].sn);
        end

        // ---------------- zero balance timing ----------------
        do_reset();
        balance = 16'd0; refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("zero_c0_busy", 32'(busy), 1);
        chk("zero_c0_done", 32'(done), 0);
        tick();
        chk("zero_c1_done",  32'(done),       1);
        chk("zero_c1_busy",  32'(busy),       0);
        chk("zero_c1_valid", 32'(coin_valid), 0);
        tick();
        chk("zero_c2_done", 32'(done), 0);

        // ---------------- hopper stall ----------------
        do_reset();
        fill_one(2'b11, 8'd5);
        balance = 16'd25; refund_req = 1'b1; coin_ack = 1'b0;
        tick();
        refund_req = 1'b0;
        tick();
        chk("stall_first_valid", 32'(coin_valid), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stall_%0d_valid", i), 32'(coin_valid), 1);
            chk($sformatf("stall_%0d_coin", i),  32'(coin_out),   3);
        end
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("stall_after_valid", 32'(coin_valid), 0);
        chk("stall_stock_q",     32'(stock_q),    4);
        wait_done(20, n, seen);
        chk("stall_done_seen", 32'(seen),      1);
        chk("stall_rem",       32'(remainder), 0);
        chk("stall_short",     32'(short),     0);
        tick();
        chk("stall_stock_q_end", 32'(stock_q), 4);

        // ---------------- fill rules ----------------
        do_reset();
        fill_one(2'b11, 8'd200);
        chk("fill_200", 32'(stock_q), 200);
        fill_one(2'b11, 8'd100);
        chk("fill_sat", 32'(stock_q), 255);
        fill_one(2'b00, 8'd50);
        chk("fill_none", {8'd0, stock_q, stock_d, stock_n}, {8'd0, 8'd255, 8'd0, 8'd0});
        balance = 16'd50; refund_req = 1'b1; coin_ack = 1'b0;
        tick();
        refund_req = 1'b0;
        tick();
        fill_valid = 1'b1; fill_coin = 2'b10; fill_count = 8'd7;
        balance = 16'd1000; refund_req = 1'b1;
        tick();
        fill_valid = 1'b0; refund_req = 1'b0;
        chk("fill_busy_ignored", 32'(stock_d), 0);
        coin_ack = 1'b1;
        wait_done(40, n, seen);
        chk("fill_busy_done_seen", 32'(seen),      1);
        chk("fill_busy_ncoins",    32'(n),         2);
        chk("fill_busy_rem",       32'(remainder), 0);
        coin_ack = 1'b0;
        mism = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || coin_valid !== 1'b0) mism++;
        end
        chk("req_busy_ignored", 32'(mism), 0);
        chk("fill_busy_stock_q", 32'(stock_q), 253);

        // ---------------- fill and refund in the same idle cycle ----------------
        do_reset();
        fill_valid = 1'b1; fill_coin = 2'b11; fill_count = 8'd1;
        balance = 16'd25; refund_req = 1'b1;
        tick();
        fill_valid = 1'b0; refund_req = 1'b0;
        coin_ack = 1'b1;
        wait_done(20, n, seen);
        coin_ack = 1'b0;
        chk("same_cycle_seen",   32'(seen),    1);
        chk("same_cycle_ncoins", 32'(n),       1);
        chk("same_cycle_short",  32'(short),   0);
        chk("same_cycle_sq",     32'(stock_q), 0);
        tick();

        // ---------------- reset mid-payout ----------------
        do_reset();
        fill_one(2'b11, 8'd3); fill_one(2'b10, 8'd3); fill_one(2'b01, 8'd3);
        balance = 16'd100; refund_req = 1'b1; coin_ack = 1'b0;
        tick();
        refund_req = 1'b0;
        tick();
        chk("midrst_pre_valid", 32'(coin_valid), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_valid",  32'(coin_valid), 0);
        chk("midrst_coin",   32'(coin_out),   0);
        chk("midrst_busy",   32'(busy),       0);
        chk("midrst_short",  32'(short),      0);
        chk("midrst_rem",    32'(remainder),  0);
        chk("midrst_stocks", {8'd0, stock_q, stock_d, stock_n}, 0);

        // ---------------- random fills and payouts vs. model ----------------
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                fill_one(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
                chk($sformatf("rand%0d_fill", it), {8'd0, stock_q, stock_d, stock_n},
                    {8'd0, 8'(mq), 8'(md), 8'(mn)});
            end else begin
                if ($urandom_range(0, 7) == 0) bal = 16'($urandom_range(0, 65535));
                else                           bal = 16'($urandom_range(0, 400));
                exp_rem = model_payout(int'(bal));
                run_payout(bal, int'($urandom_range(0, 3)));
                chk($sformatf("rand%0d_ncoins", it), 32'(got_coins.size()), 32'(exp_q.size()));
                mism = 0;
                for (int j = 0; j < got_coins.size() && j < exp_q.size(); j++)
                    if (got_coins[j] !== exp_q[j]) mism++;
                chk($sformatf("rand%0d_coin_seq_mism", it), 32'(mism), 0);
                chk($sformatf("rand%0d_rem", it),   32'(done_rem),   32'(exp_rem));
                chk($sformatf("rand%0d_short", it), 32'(done_short), 32'(exp_rem != 0));
                chk($sformatf("rand%0d_stocks", it), {8'd0, stock_q, stock_d, stock_n},
                    {8'd0, 8'(mq), 8'(md), 8'(mn)});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
